// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths, membrane type and default neuron constants
package neuron_pkg;
  localparam int DEF_NUM_NEURONS   = 4;
  localparam int ID_W              = 2;
  localparam int DEF_THRESHOLD     = 200;
  localparam int DEF_LEAK_SHIFT    = 2;
  localparam int DEF_REFRACT_TURNS = 2;
  typedef logic [7:0] vmem_t;
  function automatic vmem_t sat_add(vmem_t a, vmem_t b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/neuron_tdm_scheduler_lif_update.sv
// lif_update: leak, saturating integrate, threshold and refractory decision for one context
module lif_update
  import neuron_pkg::*;
#(
  parameter int THRESHOLD     = DEF_THRESHOLD,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
  parameter int REFRACT_TURNS = DEF_REFRACT_TURNS,
  parameter int REFR_W        = 2
) (
  input  vmem_t             i_v,
  input  vmem_t             i_pending,
  input  logic [REFR_W-1:0] i_refr,
  output vmem_t             o_v,
  output logic [REFR_W-1:0] o_refr,
  output logic              o_spike
);
  vmem_t w_leaked;
  vmem_t w_sum;
  logic  w_refract;
  logic  w_fire;
  // a refractory neuron ignores its input; otherwise leak, integrate and compare
  always_comb begin
    w_leaked  = i_v - (i_v >> LEAK_SHIFT);
    w_sum     = sat_add(w_leaked, i_pending);
    w_refract = i_refr != '0;
    w_fire    = !w_refract && (w_sum >= vmem_t'(THRESHOLD));
    o_v       = (w_refract || w_fire) ? '0 : w_sum;
    o_refr    = w_refract ? i_refr - 1'b1 : w_fire ? REFR_W'(REFRACT_TURNS) : '0;
    o_spike   = w_fire;
  end
endmodule

// File: rtl/neuron_tdm_scheduler.sv
// neuron_tdm_scheduler: round-robin LIF neuron contexts fed by a synaptic event port
module neuron_tdm_scheduler
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS   = DEF_NUM_NEURONS,
  parameter int THRESHOLD     = DEF_THRESHOLD,
  parameter int LEAK_SHIFT    = DEF_LEAK_SHIFT,
  parameter int REFRACT_TURNS = DEF_REFRACT_TURNS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_syn_valid,
  input  logic [ID_W-1:0]        i_syn_id,
  input  vmem_t                  i_syn_in,
  output logic                   o_syn_ready,
  output logic [NUM_NEURONS-1:0] o_spike_out,
  output vmem_t                  o_v_mem_out,
  output logic [ID_W-1:0]        o_v_mem_id
);
  localparam int REFR_W = $clog2(REFRACT_TURNS + 2);
  logic [ID_W-1:0]        r_cur_id;
  vmem_t                  r_pending [NUM_NEURONS];
  vmem_t                  r_v [NUM_NEURONS];
  logic [REFR_W-1:0]      r_refr [NUM_NEURONS];
  logic [NUM_NEURONS-1:0] r_spike;
  vmem_t                  r_v_mem;
  logic [ID_W-1:0]        r_v_id;
  logic                   w_in_range;
  logic                   w_accept;
  vmem_t                  w_pend_sel;
  logic [NUM_NEURONS-1:0] w_add;
  logic [NUM_NEURONS-1:0] w_clr;
  vmem_t                  w_v_next;
  logic [REFR_W-1:0]      w_refr_next;
  logic                   w_fire;
  // event handshake: out-of-range targets are always accepted and dropped
  always_comb begin
    w_in_range  = {1'b0, i_syn_id} < (ID_W + 1)'(NUM_NEURONS);
    w_pend_sel  = w_in_range ? r_pending[i_syn_id] : '0;
    o_syn_ready = w_pend_sel != 8'hFF;
    w_accept    = i_syn_valid && o_syn_ready && w_in_range;
    w_add       = '0;
    w_clr       = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      w_add[i] = w_accept && (i_syn_id == ID_W'(i));
      w_clr[i] = i_en && (r_cur_id == ID_W'(i));
    end
  end
  lif_update #(
    .THRESHOLD    (THRESHOLD),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .REFRACT_TURNS(REFRACT_TURNS),
    .REFR_W       (REFR_W)
  ) u_lif (
    .i_v      (r_v[r_cur_id]),
    .i_pending(r_pending[r_cur_id]),
    .i_refr   (r_refr[r_cur_id]),
    .o_v      (w_v_next),
    .o_refr   (w_refr_next),
    .o_spike  (w_fire)
  );
  // pending accumulators: the slot's clear wins, a same-edge event then starts a fresh sum
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_pending[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++)
        r_pending[i] <= w_clr[i] ? (w_add[i] ? i_syn_in : '0)
                                 : (w_add[i] ? sat_add(r_pending[i], i_syn_in) : r_pending[i]);
    end
  end
  // slot counter, neuron state write-back and the registered observation outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur_id <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_v[i]    <= '0;
        r_refr[i] <= '0;
      end
      r_spike <= '0;
      r_v_mem <= '0;
      r_v_id  <= '0;
    end else begin
      r_spike <= (i_en && w_fire) ? NUM_NEURONS'(1) << r_cur_id : '0;
      if (i_en) begin
        r_v[r_cur_id]    <= w_v_next;
        r_refr[r_cur_id] <= w_refr_next;
        r_v_mem          <= w_v_next;
        r_v_id           <= r_cur_id;
        r_cur_id         <= (r_cur_id == ID_W'(NUM_NEURONS - 1)) ? '0 : r_cur_id + 1'b1;
      end
    end
  end
  assign o_spike_out = r_spike;
  assign o_v_mem_out = r_v_mem;
  assign o_v_mem_id  = r_v_id;
endmodule

// File: doc/neuron_tdm_scheduler.md
NEURON_TDM_SCHEDULER -- requirements
Module: neuron_tdm_scheduler

Interface
REQ-001: Parameter NUM_NEURONS, default 4, is the number of time-multiplexed neuron contexts.
REQ-002: Parameter THRESHOLD, default 200, is the 8-bit membrane firing threshold.
REQ-003: Parameter LEAK_SHIFT, default 2, is the leak shift; leak = v >> LEAK_SHIFT.
REQ-004: Parameter REFRACT_TURNS, default 2, is the number of own update turns a neuron is refractory after a spike.
REQ-005: clk  input  1  single clock; all state updates on the rising edge.
REQ-006: rst_n  input  1  asynchronous, active-low reset.
REQ-007: en  input  1  update enable; low freezes the slot counter and all neuron updates.
REQ-008: syn_valid  input  1  synaptic event present.
REQ-009: syn_id  input  2  target neuron of the event.
REQ-010: syn_in  input  8  unsigned synaptic weight.
REQ-011: syn_ready  output  1  event accepted on the edge where syn_valid && syn_ready.
REQ-012: spike_out  output  NUM_NEURONS  one-cycle spike pulse per neuron.
REQ-013: v_mem_out  output  8  membrane value just written by the update datapath.
REQ-014: v_mem_id  output  2  neuron index of v_mem_out.

Function
REQ-015: A slot counter cur_id SHALL step 0,1,...,NUM_NEURONS-1,0 once per cycle while en=1 and hold while en=0.
REQ-016: Each neuron SHALL own pending[i] (8-bit), v[i] (8-bit) and refr[i] (counter 0..REFRACT_TURNS).
REQ-017: syn_ready SHALL be combinational: high iff pending[syn_id] != 255.
REQ-018: An accepted event SHALL add syn_in to pending[syn_id], saturating at 255.
REQ-019: In a cycle with en=1, neuron k=cur_id SHALL be updated and pending[k] cleared on the same edge.
REQ-020: If refr[k] > 0: v[k] stays 0, refr[k] decrements, consumed pending is discarded, no spike.
REQ-021: Otherwise: sum = v[k] - (v[k] >> LEAK_SHIFT) + pending[k], computed 9-bit and saturated to 255.
REQ-022: If sum >= THRESHOLD: v[k] becomes 0, refr[k] becomes REFRACT_TURNS, spike_out[k] pulses; else v[k] becomes sum.
REQ-023: spike_out, v_mem_out and v_mem_id SHALL be registered and valid the cycle after the update slot (latency 1); spike_out is 0 in all other cycles.
REQ-024: v_mem_out/v_mem_id SHALL hold their last values while en=0.
REQ-025: An event accepted for neuron k in the same cycle k is consumed SHALL NOT join that update; pending[k] becomes sat(syn_in) after the edge (clear takes precedence, then add).
REQ-026: Events SHALL continue to be accepted while en=0.
REQ-027: syn_id >= NUM_NEURONS SHALL be accepted and discarded.

Reset
REQ-028: While rst_n=0, asynchronously: cur_id=0, all v/pending/refr=0, spike_out=0, v_mem_out=0, v_mem_id=0.
REQ-029: Reset asserted mid-operation SHALL discard all pending events and refractory state; the first update after release SHALL be for neuron 0.

Structure
REQ-030: Package neuron_pkg SHALL hold NUM_NEURONS, the ID width, the 8-bit membrane type and default THRESHOLD/LEAK_SHIFT/REFRACT_TURNS.
REQ-031: A combinational sub-module lif_update SHALL compute the leak, the saturating add, the threshold compare and the refractory decision for one context; the scheduler owns all storage, the slot counter and the handshake.

Verification
REQ-032: After reset, event (id 0, 100) accepted before slot 0 -> next cycle v_mem_id=0, v_mem_out=100; after neuron 0's next turn with no input, v_mem_out=75.
REQ-033: Event (id 1, 200) from v=0 -> spike_out=4'b0010 for exactly one cycle, v_mem_out=0; events (id 1, 50) on the next two turns are discarded; the third turn yields v_mem_out=50.
REQ-034: Events (id 2, 200) then (id 2, 100) before slot 2 -> pending saturates to 255, syn_ready=0 for id 2 while syn_ready=1 for id 3; slot 2 spikes.
REQ-035: Event (id 3, 10) in the cycle cur_id=3 -> that update excludes it; neuron 3's next turn shows v_mem_out=10 (with v previously 0).
REQ-036: en=0 for 5 cycles with events for id 0 -> cur_id, v and outputs are frozen; the events still accumulate; updates resume at the frozen cur_id.
REQ-037: rst_n pulsed low mid-round with nonzero v/pending/refr -> all outputs 0 immediately; after release the first v_mem_id=0, v_mem_out=0.
